// File: rtl/uart_ram_dumper.sv
// uart_ram_dumper: on a halt rising edge, reads a RAM window over the debug port and streams it as UART 8N1 framed by A5/5A.
module uart_ram_dumper #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
   parameter int unsigned DUMP_WORDS = 1024
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        halt,
   output logic        ram_override,
   output logic        ram_req,
   output logic [31:0] ram_addr,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic        txd,
   output logic        busy,
   output logic        done
);
   localparam int unsigned CPB    = CLK_FREQ / BAUD;
   localparam int unsigned BW     = $clog2(CPB);
   localparam logic [BW-1:0] RELOAD = BW'(CPB - 1);
   localparam logic [15:0] LAST   = 16'(DUMP_WORDS - 1);
   typedef enum logic [2:0] {IDLE, HDR, REQ, SEND, TRL, DONE} state_t;
   state_t        state_q;
   logic          halt_q, arm_q, ovr_q, req_q, busy_q, done_q;
   logic [15:0]   wc_q;
   logic [31:0]   buf_q;
   logic [2:0]    cnt_q;
   logic          tx_busy_q, txd_q;
   logic [BW-1:0] baud_q;
   logic [3:0]    bit_q;
   logic [7:0]    sh_q;
   logic          start, tx_rdy, tx_state, tx_ld, fin;
   logic [2:0]    nbytes;
   logic [7:0]    tx_byte;
   // arm_q keeps a halt that is already high out of reset from counting as an edge
   assign start    = halt & ~halt_q & arm_q;
   // ready also on the last stop-bit cycle so consecutive frames abut with no idle gap
   assign tx_rdy   = ~tx_busy_q | (bit_q == 4'd9 && baud_q == '0);
   assign tx_state = state_q == HDR || state_q == SEND || state_q == TRL;
   assign nbytes   = state_q == SEND ? 3'd4 : 3'd1;
   assign tx_byte  = state_q == HDR ? 8'hA5 : state_q == TRL ? 8'h5A : buf_q[7:0];
   assign tx_ld    = tx_state && tx_rdy && cnt_q < nbytes;
   assign fin      = tx_state && tx_rdy && cnt_q == nbytes;
   assign ram_override = ovr_q;
   assign ram_req      = req_q;
   assign ram_addr     = DUMP_BASE + {14'd0, wc_q, 2'b00};
   assign txd          = txd_q;
   assign busy         = busy_q;
   assign done         = done_q;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_busy_q <= 1'b0;
         txd_q     <= 1'b1;
         baud_q    <= '0;
         bit_q     <= 4'd0;
         sh_q      <= 8'hFF;
      end else if (tx_ld) begin
         tx_busy_q <= 1'b1;
         txd_q     <= 1'b0;
         baud_q    <= RELOAD;
         bit_q     <= 4'd0;
         sh_q      <= tx_byte;
      end else if (tx_busy_q) begin
         if (baud_q != '0) begin
            baud_q <= baud_q - BW'(1);
         end else if (bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
         end else begin
            bit_q  <= bit_q + 4'd1;
            baud_q <= RELOAD;
            txd_q  <= sh_q[0];
            sh_q   <= {1'b1, sh_q[7:1]};
         end
      end
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         halt_q  <= 1'b0;
         arm_q   <= 1'b0;
         ovr_q   <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wc_q    <= 16'd0;
         buf_q   <= 32'd0;
         cnt_q   <= 3'd0;
      end else begin
         halt_q <= halt;
         if (!halt) arm_q <= 1'b1;
         if (tx_ld) begin
            cnt_q <= cnt_q + 3'd1;
            if (state_q == SEND) buf_q <= {8'd0, buf_q[31:8]};
         end
         case (state_q)
            IDLE: if (start) begin
               state_q <= HDR;
               busy_q  <= 1'b1;
               ovr_q   <= 1'b1;
               wc_q    <= 16'd0;
               cnt_q   <= 3'd0;
            end
            HDR: if (fin) begin
               cnt_q   <= 3'd0;
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: if (ram_ready) begin
               buf_q   <= ram_rdata;
               req_q   <= 1'b0;
               state_q <= SEND;
            end
            SEND: if (fin) begin
               cnt_q   <= 3'd0;
               wc_q    <= wc_q + 16'd1;
               state_q <= wc_q == LAST ? TRL : REQ;
               req_q   <= wc_q != LAST;
            end
            TRL: if (fin) begin
               cnt_q   <= 3'd0;
               state_q <= DONE;
               ovr_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            DONE: if (!halt) begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_ram_dumper.md
Name: uart_ram_dumper

Overview:
- Host-facing RAM dump engine. When the core halts, it takes over the RAM debug port and reads a fixed window of words. It streams them out over a UART 8N1 transmitter.
- This is the reader/transmit side of the RAM dump interface, whose override control the FPGA top currently ties off.
- It sits beside the system instance in the FPGA top, sharing the 50 MHz clock.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be >= 2.
- DUMP_BASE, 32'h0000_0000, byte address of the first word dumped. Must be word aligned.
- DUMP_WORDS, 1024, number of 32-bit words dumped. Range 1..65535.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- halt  input  1  core halt flag. Its rising edge starts a dump.
- ram_override  output  1  asserted while the dumper owns the RAM debug port (drives override_ctrl).
- ram_req  output  1  read request, held until ram_ready.
- ram_addr  output  32  byte address of the requested word.
- ram_rdata  input  32  read data, valid in the cycle ram_ready=1.
- ram_ready  input  1  read completion strobe.
- txd  output  1  UART serial out, idle high.
- busy  output  1  dump in progress.
- done  output  1  dump complete. Held until halt falls.

Behaviour:
- Reset values:
  - ram_override=0, ram_req=0, ram_addr=DUMP_BASE, txd=1, busy=0, done=0.
  - FSM=IDLE, word counter=0, halt edge register=0.
  - Reset is asynchronous. Reset mid-dump aborts immediately. txd returns high the same cycle, even mid-bit, and no partial frame resumes.
- Trigger:
  - halt is registered once as halt_d. start = halt & ~halt_d.
  - A start seen outside IDLE is ignored.
  - If halt is already high out of reset, no dump occurs until halt falls and rises again.
- FSM:
  - IDLE: on start go to HDR and set busy=1, ram_override=1.
  - HDR: send sync byte 8'hA5, then go to REQ.
  - REQ: assert ram_req with ram_addr = DUMP_BASE + 4*word_count.
    - ram_req and ram_addr stay stable until ram_ready.
    - On ram_ready, latch ram_rdata into a 32-bit shift buffer in the same cycle, deassert ram_req next cycle, and go to SEND.
    - ram_ready in the first REQ cycle (zero wait) is legal.
  - SEND: transmit 4 bytes, little-endian (bits 7:0 first).
    - After the 4th byte, increment word_count.
    - If word_count == DUMP_WORDS-1 before the increment, go to TRL; otherwise go to REQ.
  - TRL: send trailer byte 8'h5A, then go to DONE.
  - DONE: ram_override=0, busy=0, done=1. When halt=0, done goes to 0 and the FSM returns to IDLE.
- ram_override timing:
  - Rises the cycle after start is detected, before the first ram_req.
  - Falls on entry to DONE.
  - ram_req is never high while ram_override=0.
- UART transmitter (internal):
  - 8N1, LSB first. Frame = 1 start bit (0), 8 data bits, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - A byte load is accepted only when the transmitter is idle, so there are no back-to-back overlaps.
  - The next start bit begins the cycle after the previous stop bit completes. Within SEND there are no idle gaps between bytes.
  - One gap of at least 1 cycle is permitted between a word's last byte and the next word's first byte.
- Counters:
  - Baud counter is a ceil(log2(CLKS_PER_BIT))-bit down-counter reloaded per bit.
  - Bit index is 4 bits.
  - word_count is 16 bits. ram_addr is computed modulo 2^32, so it wraps at 32 bits.
- Stream length: exactly 1 + 4*DUMP_WORDS + 1 bytes per dump.
- halt falling mid-dump: the dump still runs to completion. DONE then exits on the first cycle it observes halt=0.

Test Plan:
- Sim parameters CLK_FREQ=1000, BAUD=100 (10 clk/bit), DUMP_BASE=32'h100, DUMP_WORDS=2. RAM model returns 32'h11223344 at 0x100 and 32'hAABBCCDD at 0x104, with ram_ready after 3 cycles.
  - Pulse halt -> ram_override=1 next cycle.
  - UART decoder receives A5 44 33 22 11 DD CC BB AA 5A.
  - ram_addr sequence is 0x100 then 0x104.
  - done=1 and ram_override=0 after the last stop bit.
- Bit timing: measure the first frame -> txd low exactly 10 cycles, then data bits of 8'hA5 LSB first (1,0,1,0,0,1,0,1) at 10 cycles each, stop high for 10 cycles.
- Zero-wait RAM (ram_ready=1 in the first REQ cycle) -> same byte stream. ram_req is high for exactly 1 cycle per word.
- Hold halt high after done, then pulse halt again without a falling edge -> no second dump.
  - Drop halt -> done=0.
  - Raise halt -> a second full 10-byte stream.
- Assert nrst=0 during byte 3 -> txd=1, ram_override=0, ram_req=0, busy=0 immediately.
  - After release with halt still high -> no dump until a new rising edge of halt.
- Drop halt mid-dump during word 0 -> all 10 bytes are still sent. done pulses for at most 1 cycle, then the FSM returns to IDLE.
